// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: default widths and producer latencies.
package hazard_pkg;

   localparam int REG_W_DEF  = 5;
   localparam int LAT_W_DEF  = 3;

   localparam int LAT_ALU    = 1;
   localparam int LAT_LOAD   = 2;
   localparam int LAT_MULDIV = 5;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage to scoreboard bundle; the pipeline side is master, the scoreboard is slave.
interface hazard_scoreboard_if #(
   parameter int REG_W = hazard_pkg::REG_W_DEF,
   parameter int LAT_W = hazard_pkg::LAT_W_DEF
);

   logic                  ID_Valid;
   logic [REG_W-1:0]      ID_Rs;
   logic [REG_W-1:0]      ID_Rt;
   logic                  ID_UseRs;
   logic                  ID_UseRt;
   logic                  ID_Branch;
   logic                  ID_RegWrite;
   logic [REG_W-1:0]      ID_WriteReg;
   logic [LAT_W-1:0]      ID_Lat;
   logic                  Flush;
   logic                  Mem_Wait;
   logic                  Stall;
   logic [2**REG_W-1:0]   Pending;
   logic [31:0]           StallCycles;

   modport master (
      output ID_Valid, ID_Rs, ID_Rt, ID_UseRs, ID_UseRt, ID_Branch,
             ID_RegWrite, ID_WriteReg, ID_Lat, Flush, Mem_Wait,
      input  Stall, Pending, StallCycles
   );

   modport slave (
      input  ID_Valid, ID_Rs, ID_Rt, ID_UseRs, ID_UseRt, ID_Branch,
             ID_RegWrite, ID_WriteReg, ID_Lat, Flush, Mem_Wait,
      output Stall, Pending, StallCycles
   );

endinterface

// File: rtl/hazard_scoreboard_sb_entry.sv
// One register's pending-latency counter: hold on freeze, saturating decrement, WAW max-load.
module hazard_sb_entry #(
   parameter int LAT_W = hazard_pkg::LAT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             hold,
   input  logic             load,
   input  logic [LAT_W-1:0] lat,
   output logic [LAT_W-1:0] cnt
);

   logic [LAT_W-1:0] cnt_r;
   logic [LAT_W-1:0] dec_s;
   logic [LAT_W-1:0] nxt_s;

   function automatic logic [LAT_W-1:0] sat_dec(input logic [LAT_W-1:0] v);
      if (v != {LAT_W{1'b0}}) begin
         return v - {{(LAT_W-1){1'b0}}, 1'b1};
      end else begin
         return {LAT_W{1'b0}};
      end
   endfunction

   // Next count: a new writer keeps whichever result arrives later.
   always_comb begin
      dec_s = sat_dec(cnt_r);
      nxt_s = dec_s;
      if (load && (lat > dec_s)) begin
         nxt_s = lat;
      end else begin
         nxt_s = dec_s;
      end
   end

   // Counter state; a memory freeze holds every in-flight latency.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_r <= {LAT_W{1'b0}};
      end else if (hold) begin
         cnt_r <= cnt_r;
      end else begin
         cnt_r <= nxt_s;
      end
   end

   assign cnt = cnt_r;

endmodule

// File: rtl/hazard_scoreboard.sv
// Latency-counting RAW hazard scoreboard for the ID stage.
// Optional macro HAZARD_PERF_EN adds a saturating stall-cycle counter on StallCycles.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_W = REG_W_DEF,
   parameter int LAT_W = LAT_W_DEF
) (
   input logic                 clk,
   input logic                 reset,
   hazard_scoreboard_if.slave  sb
);

   localparam int NREG = 2**REG_W;
   // Results forwardable within one cycle only hurt consumers that need them in ID.
   localparam logic [LAT_W-1:0] ALU_MIN_S = LAT_W'(2);
   localparam logic [LAT_W-1:0] BR_MIN_S  = LAT_W'(1);

   logic [LAT_W-1:0] cnt_s [NREG];
   logic [NREG-1:0]  pending_s;
   logic             hit_rs_s;
   logic             hit_rt_s;
   logic [LAT_W-1:0] cnt_rs_s;
   logic [LAT_W-1:0] cnt_rt_s;
   logic             stall_s;
   logic             issue_s;

   assign cnt_s[0] = {LAT_W{1'b0}};

   for (genvar r = 1; r < NREG; r++) begin : g_entry
      hazard_sb_entry #(.LAT_W(LAT_W)) u_entry (
         .clk   (clk),
         .reset (reset),
         .hold  (sb.Mem_Wait),
         .load  (issue_s && (sb.ID_WriteReg == REG_W'(r))),
         .lat   (sb.ID_Lat),
         .cnt   (cnt_s[r])
      );
   end

   // Source-operand hazard detection against the live counters.
   always_comb begin
      hit_rs_s = sb.ID_UseRs && (sb.ID_Rs != {REG_W{1'b0}});
      hit_rt_s = sb.ID_UseRt && (sb.ID_Rt != {REG_W{1'b0}});
      cnt_rs_s = cnt_s[sb.ID_Rs];
      cnt_rt_s = cnt_s[sb.ID_Rt];
      stall_s  = 1'b0;
      if (sb.ID_Valid && !sb.Flush) begin
         stall_s = (hit_rs_s && (cnt_rs_s >= ALU_MIN_S))
                || (hit_rt_s && (cnt_rt_s >= ALU_MIN_S))
                || (sb.ID_Branch && ((hit_rs_s && (cnt_rs_s >= BR_MIN_S))
                                  || (hit_rt_s && (cnt_rt_s >= BR_MIN_S))));
      end else begin
         stall_s = 1'b0;
      end
   end

   assign issue_s = sb.ID_Valid && !stall_s && !sb.Flush && !sb.Mem_Wait
                 && sb.ID_RegWrite && (sb.ID_WriteReg != {REG_W{1'b0}});

   // Pending bits straight from counter flops.
   always_comb begin
      pending_s = {NREG{1'b0}};
      for (int r = 0; r < NREG; r++) begin
         pending_s[r] = (cnt_s[r] != {LAT_W{1'b0}});
      end
   end

   assign sb.Stall   = stall_s;
   assign sb.Pending = pending_s;

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cycles_r;

   // Saturating count of stalled cycles.
   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cycles_r <= 32'd0;
      end else if (stall_s && (stall_cycles_r != 32'hFFFF_FFFF)) begin
         stall_cycles_r <= stall_cycles_r + 32'd1;
      end else begin
         stall_cycles_r <= stall_cycles_r;
      end
   end

   assign sb.StallCycles = stall_cycles_r;
`else
   assign sb.StallCycles = 32'd0;
`endif

endmodule
